// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 48-bit add/sub macro among NUM_REQ requesters.
// Results return tagged with the issuing requester's ID two cycles after grant.

module addsub_macro (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        CARRYIN,
    input  logic        ADD_SUB,
    input  logic [47:0] A,
    input  logic [47:0] B,
    output logic [47:0] RESULT,
    output logic        CARRYOUT
);

    logic [47:0] a_q;
    logic [47:0] b_q;
    logic        add_q;
    logic        cin_q;
    logic [48:0] sum;
    logic [48:0] out_q;

    // Subtract carry is the borrow: bit 48 of the 49-bit difference
    always_comb begin
        sum = '0;
        if (add_q)
            sum = {1'b0, a_q} + {1'b0, b_q} + {48'd0, cin_q};
        else
            sum = {1'b0, a_q} - {1'b0, b_q} - {48'd0, cin_q};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q   <= '0;
            b_q   <= '0;
            add_q <= 1'b1;
            cin_q <= 1'b0;
            out_q <= '0;
        end else if (CE) begin
            a_q   <= A;
            b_q   <= B;
            add_q <= ADD_SUB;
            cin_q <= CARRYIN;
            out_q <= sum;
        end
    end

    assign RESULT   = out_q[47:0];
    assign CARRYOUT = out_q[48];

endmodule

module addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*48-1:0] req_a,
    input  logic [NUM_REQ*48-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [47:0]           rsp_result,
    output logic                  rsp_carry,
    output logic                  busy
);

    logic [ID_W-1:0] rr_ptr;
    logic            rst_q;
    logic            blocked;
    logic [ID_W:0]   scan;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    logic [47:0]     op_a;
    logic [47:0]     op_b;
    logic            op_add;
    logic            v1;
    logic            v2;
    logic [ID_W-1:0] id1;
    logic [ID_W-1:0] id2;

    // Grants stay off for one extra cycle after reset releases
    assign blocked = RST | rst_q;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ))
                scan = scan - (ID_W+1)'(NUM_REQ);
            if (!gnt_vld && req_valid[scan[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan[ID_W-1:0];
            end
        end
        if (blocked)
            gnt_vld = 1'b0;
    end

    always_comb begin
        req_ready = '0;
        op_a      = '0;
        op_b      = '0;
        op_add    = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vld && gnt_id == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                op_a         = req_a[48*i +: 48];
                op_b         = req_b[48*i +: 48];
                op_add       = ~req_sub[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rst_q  <= 1'b1;
            rr_ptr <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            id1    <= '0;
            id2    <= '0;
        end else begin
            rst_q <= 1'b0;
            if (gnt_vld) begin
                if (gnt_id == ID_W'(NUM_REQ-1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= gnt_id + 1'b1;
            end
            v1  <= gnt_vld;
            id1 <= gnt_id;
            v2  <= v1;
            id2 <= id1;
        end
    end

    addsub_macro u_macro (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (1'b1),
        .CARRYIN  (1'b0),
        .ADD_SUB  (op_add),
        .A        (op_a),
        .B        (op_b),
        .RESULT   (rsp_result),
        .CARRYOUT (rsp_carry)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = v2 & ~RST & (id2 == ID_W'(i));
    end

    assign busy = (v1 | v2) & ~RST;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: reset, arithmetic, fairness,
// pointer skip, streaming and reset during flight.

module tb_addsub_arbiter;

    logic         CLK;
    logic         RST;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [191:0] req_a;
    logic [191:0] req_b;
    logic [3:0]   req_sub;
    logic [3:0]   rsp_valid;
    logic [47:0]  rsp_result;
    logic         rsp_carry;
    logic         busy;

    int total;
    int bad;

    addsub_arbiter #(.NUM_REQ(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .busy       (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input int i, input logic [47:0] a,
                          input logic [47:0] b, input logic sub);
        req_a[48*i +: 48] = a;
        req_b[48*i +: 48] = b;
        req_sub[i]        = sub;
    endtask

    task automatic apply_reset();
        RST       = 1'b1;
        req_valid = '0;
        next_cycle();
        next_cycle();
        RST = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        req_valid = 4'b1111;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_ready got=%b exp=0000", req_ready);
        end
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle rsp_valid=%b busy=%b exp=0000/0", rsp_valid, busy);
        end
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_first_cycle_ready got=%b exp=0000", req_ready);
        end
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_first_cycle_idle rsp_valid=%b busy=%b", rsp_valid, busy);
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_single_op();
        set_op(2, 48'd100, 48'd58, 1'b1);
        req_valid = 4'b0100;
        @(negedge CLK);
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_ready got=%b exp=0100", req_ready);
        end
        next_cycle();
        req_valid = '0;
        @(negedge CLK);
        total++;
        if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
            bad++;
            $display("FAIL single_t1 busy=%b rsp_valid=%b exp=1/0000", busy, rsp_valid);
        end
        next_cycle();
        @(negedge CLK);
        total++;
        if (rsp_valid !== 4'b0100 || rsp_result !== 48'd42 || rsp_carry !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp got=%b/%0d/%b exp=0100/42/0",
                     rsp_valid, rsp_result, rsp_carry);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_t2_busy got=%b exp=1", busy);
        end
        next_cycle();
        @(negedge CLK);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_t3_busy got=%b exp=0", busy);
        end
        next_cycle();
    endtask

    task automatic test_borrow_carry();
        set_op(0, 48'd5, 48'd7, 1'b1);
        req_valid = 4'b0001;
        @(negedge CLK);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL borrow_ready got=%b exp=0001", req_ready);
        end
        next_cycle();
        set_op(1, 48'hFFFF_FFFF_FFFF, 48'd1, 1'b0);
        req_valid = 4'b0010;
        @(negedge CLK);
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL carry_ready got=%b exp=0010", req_ready);
        end
        next_cycle();
        req_valid = '0;
        @(negedge CLK);
        total++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 48'hFFFF_FFFF_FFFE || rsp_carry !== 1'b1) begin
            bad++;
            $display("FAIL borrow_rsp got=%b/%h/%b exp=0001/fffffffffffe/1",
                     rsp_valid, rsp_result, rsp_carry);
        end
        next_cycle();
        @(negedge CLK);
        total++;
        if (rsp_valid !== 4'b0010 || rsp_result !== 48'd0 || rsp_carry !== 1'b1) begin
            bad++;
            $display("FAIL carry_rsp got=%b/%h/%b exp=0010/0/1",
                     rsp_valid, rsp_result, rsp_carry);
        end
        next_cycle();
    endtask

    task automatic test_fairness();
        int          round [4];
        int          cnt   [4];
        int          g;
        int          r;
        logic [47:0] exp_res;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            round[i] = 0;
            cnt[i]   = 0;
        end
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 4; i++) begin
                set_op(i, 48'(100*i + 10*round[i]), 48'(i + 1), 1'b0);
                req_valid[i] = (round[i] < 2);
            end
            @(negedge CLK);
            if (c < 8) begin
                total++;
                if (req_ready !== (4'b0001 << (c % 4))) begin
                    bad++;
                    $display("FAIL fair_grant c=%0d got=%b exp=%b",
                             c, req_ready, 4'b0001 << (c % 4));
                end
                round[c % 4]++;
            end
            if (c >= 2) begin
                g       = (c - 2) % 4;
                r       = (c - 2) / 4;
                exp_res = 48'(100*g + 10*r + g + 1);
                total++;
                if (rsp_valid !== (4'b0001 << g) || rsp_result !== exp_res) begin
                    bad++;
                    $display("FAIL fair_rsp c=%0d got=%b/%0d exp=%b/%0d",
                             c, rsp_valid, rsp_result, 4'b0001 << g, exp_res);
                end
            end
            for (int i = 0; i < 4; i++)
                cnt[i] += int'(rsp_valid[i]);
            next_cycle();
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cnt[i] !== 2) begin
                bad++;
                $display("FAIL fair_count req=%0d got=%0d exp=2", i, cnt[i]);
            end
        end
    endtask

    task automatic test_pointer_skip();
        logic [3:0] exp_gnt [4];
        exp_gnt[0] = 4'b0001;
        exp_gnt[1] = 4'b1000;
        exp_gnt[2] = 4'b0001;
        exp_gnt[3] = 4'b1000;
        set_op(0, 48'd1, 48'd1, 1'b0);
        set_op(3, 48'd3, 48'd3, 1'b0);
        for (int c = 0; c < 4; c++) begin
            req_valid = (c == 0) ? 4'b0001 : 4'b1001;
            @(negedge CLK);
            total++;
            if (req_ready !== exp_gnt[c]) begin
                bad++;
                $display("FAIL skip_grant c=%0d got=%b exp=%b", c, req_ready, exp_gnt[c]);
            end
            next_cycle();
        end
        req_valid = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                set_op(1, 48'(c), 48'(c), 1'b0);
                req_valid = 4'b0010;
            end else begin
                req_valid = '0;
            end
            @(negedge CLK);
            if (c < 16) begin
                total++;
                if (req_ready !== 4'b0010) begin
                    bad++;
                    $display("FAIL b2b_ready c=%0d got=%b exp=0010", c, req_ready);
                end
            end
            total++;
            if (c < 2) begin
                if (rsp_valid !== 4'b0000) begin
                    bad++;
                    $display("FAIL b2b_early c=%0d got=%b exp=0000", c, rsp_valid);
                end
            end else if (rsp_valid !== 4'b0010 || rsp_result !== 48'(2*(c-2))) begin
                bad++;
                $display("FAIL b2b_rsp c=%0d got=%b/%0d exp=0010/%0d",
                         c, rsp_valid, rsp_result, 2*(c-2));
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        set_op(1, 48'd1, 48'd2, 1'b0);
        req_valid = 4'b0010;
        @(negedge CLK);
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL mid_grant got=%b exp=0010", req_ready);
        end
        next_cycle();
        req_valid = '0;
        RST       = 1'b1;
        @(negedge CLK);
        total++;
        if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mid_rst_cycle rsp_valid=%b ready=%b exp=0000/0000",
                     rsp_valid, req_ready);
        end
        next_cycle();
        RST = 1'b0;
        for (int i = 0; i < 4; i++)
            set_op(i, 48'(i), 48'd0, 1'b0);
        req_valid = 4'b1111;
        @(negedge CLK);
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mid_t2 rsp_valid=%b busy=%b ready=%b exp=0000/0/0000",
                     rsp_valid, busy, req_ready);
        end
        next_cycle();
        @(negedge CLK);
        total++;
        if (rsp_valid !== 4'b0000) begin
            bad++;
            $display("FAIL mid_t3_rsp got=%b exp=0000", rsp_valid);
        end
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_ptr_reset got=%b exp=0001", req_ready);
        end
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        RST       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        #1;
        test_reset();
        test_single_op();
        test_borrow_carry();
        test_fairness();
        test_pointer_skip();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
